image_paste: RTL and testbench
==============================

# image_paste

Inverse of the crop stage on the DVP video path. It generates a full H_DISP×V_DISP output raster with its own sync timing. It pulls a sub-window pixel stream through a valid/ready handshake and places it at (start_x, start_y)–(end_x, end_y). Every other active pixel is filled with a background colour. It sits between a cropped or processed window source (scaler, FIFO, DMA reader) and the display encoder.

## Interface
Parameters:
- H_DISP, 12'd1280, active pixels per line
- V_DISP, 12'd720, active lines per frame
- H_FP / H_SYNC / H_BP, 110 / 40 / 220, horizontal porch and sync widths in clocks
- V_FP / V_SYNC / V_BP, 5 / 5 / 20, vertical porch and sync widths in lines
- X_RES_WIDTH, 11, width of the x window coordinates
- Y_RES_WIDTH, 11, width of the y window coordinates

Ports:
- clk  in  1  pixel clock
- rst  in  1  synchronous, active-high reset
- start_x / end_x  in  X_RES_WIDTH  window columns, half-open [start_x, end_x)
- start_y / end_y  in  Y_RES_WIDTH  window rows, half-open [start_y, end_y)
- bg_rgb  in  24  fill colour outside the window
- in_valid  in  1  window pixel available
- in_sof  in  1  marks the first pixel of a window frame
- in_rgb  in  24  window pixel
- in_ready  out  1  window pixel accepted this cycle when high with in_valid
- hs_o, vs_o, de_o  out  1 each  active-high sync and data enable
- rgb_o  out  24  output pixel, 0 when de_o is low
- err_o  out  1  one-cycle pulse on underflow or misplaced in_sof

## Operation
- Counters: h_cnt runs 0..H_TOTAL-1, where H_TOTAL = H_DISP+H_FP+H_SYNC+H_BP.
- v_cnt runs 0..V_TOTAL-1 and increments when h_cnt wraps.
- Active region: h_cnt < H_DISP and v_cnt < V_DISP.
- hs asserts for h_cnt in [H_DISP+H_FP, H_DISP+H_FP+H_SYNC).
- vs asserts for v_cnt in [V_DISP+V_FP, V_DISP+V_FP+V_SYNC).
- All comparisons are unsigned 12-bit, with coordinates zero-extended.
- Window latch: start_x, end_x, start_y and end_y are sampled when h_cnt==0 and v_cnt==0, and are held for the whole frame.
- win_hit = active ∧ x_lat_start ≤ h_cnt < x_lat_end ∧ y_lat_start ≤ v_cnt < y_lat_end.
- If end ≤ start on either axis, the window is empty and win_hit never asserts.
- Input alignment FSM, state SYNC (reset state):
  - in_ready = in_valid ∧ ¬in_sof, so beats that are not a start of frame are discarded.
  - An in_sof beat is held (in_ready low).
  - Go to RUN when win_hit is high at the window origin (h_cnt==x_lat_start ∧ v_cnt==y_lat_start) and the head beat has in_sof=1; that beat is consumed in the same cycle.
- Input alignment FSM, state RUN:
  - in_ready = win_hit, regardless of in_valid.
  - Accept when win_hit ∧ in_valid ∧ in_sof = 1 at the window origin: normal, stay in RUN.
  - Accept with in_sof=1 at any other window pixel: pulse err_o, output bg_rgb for that pixel, return to SYNC without consuming the beat (in_ready forced low that cycle).
  - Origin pixel accepted with in_sof=0: pulse err_o, output the pixel anyway, stay in RUN.
  - win_hit ∧ ¬in_valid (underflow): output bg_rgb, pulse err_o, stay in RUN. No catch-up, so later pixels shift.
- Pixel mux:
  - inside the window with a beat accepted → in_rgb
  - inside the window without a valid beat → bg_rgb
  - active but outside the window → bg_rgb
  - inactive → 24'h0

## Timing
- Reset values: h_cnt=0, v_cnt=0, state SYNC, hs_o=vs_o=de_o=0, rgb_o=0, err_o=0, latched window = 0.
- First clock after reset deasserts: the latch samples the ports (h_cnt==0, v_cnt==0).
- in_ready is combinational from the counters, the FSM state and the head beat. Pixels are transferred on the in_valid ∧ in_ready rising edge.
- All outputs are registered with 1-cycle latency. hs_o, vs_o, de_o, rgb_o and err_o at cycle t+1 reflect the counters and handshake at cycle t, so they are mutually aligned.
- Reset mid-frame: the outputs clear on the next edge and the raster restarts at (0,0).
- Reset mid-frame, input side: any partially consumed window frame is discarded by the SYNC drain.
- Window port changes mid-frame take effect at the next frame.

## Structure
- Shared package image_pkg holds:
  - the FSM enum {SYNC, RUN}
  - 720p timing default constants, reused by the other VP blocks
  - the 24-bit RGB typedef
- Sub-module video_timing_gen (counters, hs/vs/active, frame-start strobe, h_cnt/v_cnt outputs) instantiated once; the window, FSM and mux logic stay in image_paste.

## Test plan
Bench parameters for all scenarios: H_DISP=8, V_DISP=4, all porches/syncs=1, window (2,1)–(5,3), bg_rgb=24'h0000FF.
- Source always valid, in_sof on pixel 0 of a 6-pixel frame with values 1..6 → rows 1–2, columns 2–4 carry 1..6 in raster order; all other active pixels are 0000FF. in_ready is high exactly 6 cycles per frame; err_o stays 0.
- Reset held 3 cycles, then released → hs/vs/de/rgb are 0 during reset. de_o first rises 1 cycle after release; hs_o first rises at the first clock with h_cnt=9 plus 1 cycle.
- Three junk beats (in_sof=0), then an sof frame → the junk is consumed in SYNC. Placement starts at the next window origin and matches the first scenario.
- in_valid dropped for the pixel at (3,1) → rgb there is 0000FF and err_o pulses once. The remaining 5 pixels follow, shifted by one.
- in_sof asserted on the 4th window beat → err_o pulses, the FSM enters SYNC and the beat is held. It is placed at the next frame's origin.
- end_x=start_x=4 written mid-frame → the current frame is unchanged. From the next frame, in_ready stays 0 and all active pixels are 0000FF.

Source files
------------

// File: rtl/image_pkg.sv
// Shared video-path definitions: pixel type, paste FSM states and 720p timing defaults.
// Other VP blocks import the same timing constants.
package image_pkg;

  typedef logic [23:0] rgb_t;

  typedef enum logic {
    SYNC,
    RUN
  } paste_state_e;

  localparam logic [11:0] H_DISP_720P = 12'd1280;
  localparam logic [11:0] V_DISP_720P = 12'd720;
  localparam logic [11:0] H_FP_720P   = 12'd110;
  localparam logic [11:0] H_SYNC_720P = 12'd40;
  localparam logic [11:0] H_BP_720P   = 12'd220;
  localparam logic [11:0] V_FP_720P   = 12'd5;
  localparam logic [11:0] V_SYNC_720P = 12'd5;
  localparam logic [11:0] V_BP_720P   = 12'd20;

  // Half-open unsigned range test [lo, hi); empty when hi <= lo.
  function automatic logic in_range(input logic [11:0] val, input logic [11:0] lo,
                                    input logic [11:0] hi);
    return (val >= lo) && (val < hi);
  endfunction

endpackage

// File: rtl/image_paste_if.sv
// Window pixel stream into image_paste: valid/ready handshake with a start-of-frame marker.
interface image_paste_if;
  import image_pkg::*;

  logic in_valid;
  logic in_sof;
  rgb_t in_rgb;
  logic in_ready;

  modport master (
    output in_valid,
    output in_sof,
    output in_rgb,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_sof,
    input  in_rgb,
    output in_ready
  );

endinterface

// File: rtl/video_timing_gen.sv
// Raster counters with combinational sync, active and frame-start decodes.
module video_timing_gen
  import image_pkg::*;
#(
  parameter logic [11:0] H_DISP = H_DISP_720P,
  parameter logic [11:0] V_DISP = V_DISP_720P,
  parameter logic [11:0] H_FP   = H_FP_720P,
  parameter logic [11:0] H_SYNC = H_SYNC_720P,
  parameter logic [11:0] H_BP   = H_BP_720P,
  parameter logic [11:0] V_FP   = V_FP_720P,
  parameter logic [11:0] V_SYNC = V_SYNC_720P,
  parameter logic [11:0] V_BP   = V_BP_720P
) (
  input  logic        clk,
  input  logic        rst,
  output logic [11:0] h_cnt,
  output logic [11:0] v_cnt,
  output logic        hs,
  output logic        vs,
  output logic        active,
  output logic        frame_start
);

  localparam logic [11:0] H_TOTAL = H_DISP + H_FP + H_SYNC + H_BP;
  localparam logic [11:0] V_TOTAL = V_DISP + V_FP + V_SYNC + V_BP;
  localparam logic [11:0] HS_BEG  = H_DISP + H_FP;
  localparam logic [11:0] HS_END  = H_DISP + H_FP + H_SYNC;
  localparam logic [11:0] VS_BEG  = V_DISP + V_FP;
  localparam logic [11:0] VS_END  = V_DISP + V_FP + V_SYNC;

  logic [11:0] h_cnt_q, h_cnt_d;
  logic [11:0] v_cnt_q, v_cnt_d;
  logic        h_wrap;

  always_comb begin
    h_wrap  = (h_cnt_q == H_TOTAL - 12'd1);
    h_cnt_d = h_wrap ? 12'd0 : h_cnt_q + 12'd1;
    v_cnt_d = v_cnt_q;
    if (h_wrap) begin
      v_cnt_d = (v_cnt_q == V_TOTAL - 12'd1) ? 12'd0 : v_cnt_q + 12'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt_q <= 12'd0;
      v_cnt_q <= 12'd0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

  always_comb begin
    h_cnt       = h_cnt_q;
    v_cnt       = v_cnt_q;
    hs          = in_range(h_cnt_q, HS_BEG, HS_END);
    vs          = in_range(v_cnt_q, VS_BEG, VS_END);
    active      = (h_cnt_q < H_DISP) && (v_cnt_q < V_DISP);
    frame_start = (h_cnt_q == 12'd0) && (v_cnt_q == 12'd0);
  end

endmodule

// File: rtl/image_paste.sv
// Pastes a handshaked sub-window stream into a full raster filled with a background colour.
// The alignment FSM keeps the window stream locked to the window origin via in_sof.
module image_paste
  import image_pkg::*;
#(
  parameter logic [11:0] H_DISP      = H_DISP_720P,
  parameter logic [11:0] V_DISP      = V_DISP_720P,
  parameter logic [11:0] H_FP        = H_FP_720P,
  parameter logic [11:0] H_SYNC      = H_SYNC_720P,
  parameter logic [11:0] H_BP        = H_BP_720P,
  parameter logic [11:0] V_FP        = V_FP_720P,
  parameter logic [11:0] V_SYNC      = V_SYNC_720P,
  parameter logic [11:0] V_BP        = V_BP_720P,
  parameter int unsigned X_RES_WIDTH = 11,
  parameter int unsigned Y_RES_WIDTH = 11
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [X_RES_WIDTH-1:0] start_x,
  input  logic [X_RES_WIDTH-1:0] end_x,
  input  logic [Y_RES_WIDTH-1:0] start_y,
  input  logic [Y_RES_WIDTH-1:0] end_y,
  input  rgb_t                   bg_rgb,
  image_paste_if.slave           in_if,
  output logic                   hs_o,
  output logic                   vs_o,
  output logic                   de_o,
  output rgb_t                   rgb_o,
  output logic                   err_o
);

  logic [11:0] h_cnt, v_cnt;
  logic        hs, vs, active, frame_start;

  video_timing_gen #(
    .H_DISP (H_DISP),
    .V_DISP (V_DISP),
    .H_FP   (H_FP),
    .H_SYNC (H_SYNC),
    .H_BP   (H_BP),
    .V_FP   (V_FP),
    .V_SYNC (V_SYNC),
    .V_BP   (V_BP)
  ) u_timing (
    .clk         (clk),
    .rst         (rst),
    .h_cnt       (h_cnt),
    .v_cnt       (v_cnt),
    .hs          (hs),
    .vs          (vs),
    .active      (active),
    .frame_start (frame_start)
  );

  logic [11:0] x_start_q, x_end_q, y_start_q, y_end_q;
  logic [11:0] x_start, x_end, y_start, y_end;
  logic        win_hit, at_origin;

  // On the frame-start clock the ports are used directly so a window at (0,0) sees the new
  // values in the same cycle they are latched.
  always_comb begin
    x_start   = frame_start ? 12'(start_x) : x_start_q;
    x_end     = frame_start ? 12'(end_x)   : x_end_q;
    y_start   = frame_start ? 12'(start_y) : y_start_q;
    y_end     = frame_start ? 12'(end_y)   : y_end_q;
    win_hit   = active && in_range(h_cnt, x_start, x_end) && in_range(v_cnt, y_start, y_end);
    at_origin = (h_cnt == x_start) && (v_cnt == y_start);
  end

  paste_state_e state_q, state_d;
  logic         in_ready;
  logic         take;
  logic         err;
  rgb_t         pix;

  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    take     = 1'b0;
    err      = 1'b0;
    unique case (state_q)
      SYNC: begin
        if (win_hit && at_origin && in_if.in_valid && in_if.in_sof) begin
          in_ready = 1'b1;
          take     = 1'b1;
          state_d  = RUN;
        end else begin
          // Drain anything that is not a frame start; hold the in_sof beat.
          in_ready = in_if.in_valid && !in_if.in_sof;
        end
      end
      RUN: begin
        in_ready = win_hit;
        if (win_hit) begin
          if (!in_if.in_valid) begin
            err = 1'b1;
          end else if (in_if.in_sof && !at_origin) begin
            // Early frame start: leave the beat in place for the next origin.
            in_ready = 1'b0;
            err      = 1'b1;
            state_d  = SYNC;
          end else begin
            take = 1'b1;
            err  = at_origin && !in_if.in_sof;
          end
        end
      end
      default: state_d = SYNC;
    endcase

    if (!active) begin
      pix = 24'h0;
    end else if (take) begin
      pix = in_if.in_rgb;
    end else begin
      pix = bg_rgb;
    end
  end

  assign in_if.in_ready = in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= SYNC;
      x_start_q <= 12'd0;
      x_end_q   <= 12'd0;
      y_start_q <= 12'd0;
      y_end_q   <= 12'd0;
      hs_o      <= 1'b0;
      vs_o      <= 1'b0;
      de_o      <= 1'b0;
      rgb_o     <= 24'h0;
      err_o     <= 1'b0;
    end else begin
      state_q <= state_d;
      if (frame_start) begin
        x_start_q <= x_start;
        x_end_q   <= x_end;
        y_start_q <= y_start;
        y_end_q   <= y_end;
      end
      hs_o  <= hs;
      vs_o  <= vs;
      de_o  <= active;
      rgb_o <= pix;
      err_o <= err;
    end
  end

endmodule

// File: tb/tb_image_paste.sv
// Directed bench for image_paste on an 8x4 raster (11x7 total) with window (2,1)-(5,3).
module tb_image_paste;
  import image_pkg::*;

  localparam int HT = 11;
  localparam int VT = 7;
  localparam int FR = HT * VT;
  localparam logic [23:0] BG = 24'h0000FF;

  typedef struct {
    logic        sof;
    logic [23:0] rgb;
  } beat_t;

  logic        clk;
  logic        rst;
  logic [10:0] start_x, end_x, start_y, end_y;
  rgb_t        bg_rgb;
  logic        hs_o, vs_o, de_o, err_o;
  rgb_t        rgb_o;

  image_paste_if u_if ();

  image_paste #(
    .H_DISP      (12'd8),
    .V_DISP      (12'd4),
    .H_FP        (12'd1),
    .H_SYNC      (12'd1),
    .H_BP        (12'd1),
    .V_FP        (12'd1),
    .V_SYNC      (12'd1),
    .V_BP        (12'd1),
    .X_RES_WIDTH (11),
    .Y_RES_WIDTH (11)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start_x (start_x),
    .end_x   (end_x),
    .start_y (start_y),
    .end_y   (end_y),
    .bg_rgb  (bg_rgb),
    .in_if   (u_if.slave),
    .hs_o    (hs_o),
    .vs_o    (vs_o),
    .de_o    (de_o),
    .rgb_o   (rgb_o),
    .err_o   (err_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int          n_checks;
  int          n_fail;
  beat_t       q[$];
  int          drop_k;
  int          chg_k;
  logic [23:0] rgb_s [2*FR];
  logic        hs_s  [2*FR];
  logic        vs_s  [2*FR];
  logic        de_s  [2*FR];
  logic        err_s [2*FR];
  logic        rdy_s [2*FR];
  logic [23:0] exp_win [6];
  int          win_off [6] = '{13, 14, 15, 24, 25, 26};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_frame(input logic [23:0] first, input int n);
    for (int i = 0; i < n; i++) begin
      q.push_back('{sof: (i == 0), rgb: first + 24'(i)});
    end
  endtask

  // Holds reset for three clocks; leaves the bench at a negedge with reset released.
  task automatic do_reset(input string pfx);
    logic bad;
    bad = 1'b0;
    @(negedge clk);
    rst            = 1'b1;
    start_x        = 11'd2;
    end_x          = 11'd5;
    start_y        = 11'd1;
    end_y          = 11'd3;
    bg_rgb         = BG;
    u_if.in_valid  = 1'b0;
    u_if.in_sof    = 1'b0;
    u_if.in_rgb    = 24'h0;
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
      bad = bad | hs_o | vs_o | de_o | err_o | (rgb_o != 24'h0);
    end
    check({pfx, "_reset_outs"}, 32'(bad), 32'd0);
    rst = 1'b0;
  endtask

  // Cycle k's handshake is sampled before posedge k; its outputs are sampled at the next negedge.
  task automatic run(input int ncyc);
    logic fire;
    for (int k = 0; k < ncyc; k++) begin
      if (k == chg_k) begin
        start_x = 11'd4;
        end_x   = 11'd4;
      end
      u_if.in_valid = (q.size() > 0) && (k != drop_k);
      if (q.size() > 0) begin
        u_if.in_sof = q[0].sof;
        u_if.in_rgb = q[0].rgb;
      end else begin
        u_if.in_sof = 1'b0;
        u_if.in_rgb = 24'h0;
      end
      #1;
      rdy_s[k] = u_if.in_ready;
      fire     = u_if.in_valid && u_if.in_ready;
      @(posedge clk);
      if (fire) void'(q.pop_front());
      @(negedge clk);
      rgb_s[k] = rgb_o;
      hs_s[k]  = hs_o;
      vs_s[k]  = vs_o;
      de_s[k]  = de_o;
      err_s[k] = err_o;
    end
  endtask

  task automatic check_frame(input int f, input string pfx, input int exp_ready);
    int base, bad, rdy, h, v;
    logic act, inwin;
    base = f * FR;
    bad  = 0;
    rdy  = 0;
    for (int i = 0; i < 6; i++) begin
      check($sformatf("%s_pix%0d", pfx, i), 32'(rgb_s[base + win_off[i]]), 32'(exp_win[i]));
    end
    for (int p = 0; p < FR; p++) begin
      h     = p % HT;
      v     = p / HT;
      act   = (h < 8) && (v < 4);
      inwin = act && (h >= 2) && (h < 5) && (v >= 1) && (v < 3);
      if (de_s[base + p] != act || hs_s[base + p] != (h == 9) || vs_s[base + p] != (v == 5))
        bad++;
      if (!act && rgb_s[base + p] != 24'h0) bad++;
      if (act && !inwin && rgb_s[base + p] != BG) bad++;
      if (rdy_s[base + p]) rdy++;
    end
    check({pfx, "_raster"}, 32'(bad), 32'd0);
    check({pfx, "_ready_cnt"}, 32'(rdy), 32'(exp_ready));
  endtask

  task automatic check_err(input string pfx, input int ncyc, input int exp_n, input int exp_pos);
    int n, pos;
    n   = 0;
    pos = -1;
    for (int k = 0; k < ncyc; k++) begin
      if (err_s[k]) begin
        if (pos < 0) pos = k;
        n++;
      end
    end
    check({pfx, "_err_cnt"}, 32'(n), 32'(exp_n));
    check({pfx, "_err_pos"}, 32'(pos), 32'(exp_pos));
  endtask

  initial begin
    int first_de, first_hs, first_vs;
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;

    // Always-valid source, two back-to-back frames.
    drop_k = -1;
    chg_k  = -1;
    q.delete();
    push_frame(24'd1, 6);
    push_frame(24'd7, 6);
    do_reset("s1");
    run(2 * FR);
    exp_win = '{24'd1, 24'd2, 24'd3, 24'd4, 24'd5, 24'd6};
    check_frame(0, "s1_f0", 6);
    exp_win = '{24'd7, 24'd8, 24'd9, 24'd10, 24'd11, 24'd12};
    check_frame(1, "s1_f1", 6);
    check_err("s1", 2 * FR, 0, -1);
    first_de = -1;
    first_hs = -1;
    first_vs = -1;
    for (int k = 0; k < 2 * FR; k++) begin
      if (de_s[k] && first_de < 0) first_de = k;
      if (hs_s[k] && first_hs < 0) first_hs = k;
      if (vs_s[k] && first_vs < 0) first_vs = k;
    end
    check("s1_first_de", 32'(first_de), 32'd0);
    check("s1_first_hs", 32'(first_hs), 32'd9);
    check("s1_first_vs", 32'(first_vs), 32'd55);

    // Junk beats ahead of the frame are drained while in SYNC.
    q.delete();
    for (int i = 0; i < 3; i++) q.push_back('{sof: 1'b0, rgb: 24'hAA0000 + 24'(i)});
    push_frame(24'd1, 6);
    do_reset("s2");
    run(FR);
    exp_win = '{24'd1, 24'd2, 24'd3, 24'd4, 24'd5, 24'd6};
    check_frame(0, "s2_f0", 9);
    check_err("s2", FR, 0, -1);
    check("s2_queue_empty", 32'(q.size()), 32'd0);

    // Underflow at (3,1): background there, later pixels slip by one.
    q.delete();
    push_frame(24'd1, 6);
    drop_k = 1 * HT + 3;
    do_reset("s3");
    run(FR);
    exp_win = '{24'd1, BG, 24'd2, 24'd3, 24'd4, 24'd5};
    check_frame(0, "s3_f0", 6);
    check_err("s3", FR, 1, 14);
    check("s3_left_over", 32'(q[0].rgb), 32'd6);

    // Early in_sof on the 4th window beat: resync to the next frame origin.
    drop_k = -1;
    q.delete();
    push_frame(24'd1, 3);
    push_frame(24'h10, 6);
    do_reset("s4");
    run(2 * FR);
    exp_win = '{24'd1, 24'd2, 24'd3, BG, BG, BG};
    check_frame(0, "s4_f0", 3);
    exp_win = '{24'h10, 24'h11, 24'h12, 24'h13, 24'h14, 24'h15};
    check_frame(1, "s4_f1", 6);
    check_err("s4", 2 * FR, 1, 24);

    // Empty window written mid-frame takes effect from the next frame.
    q.delete();
    push_frame(24'd1, 6);
    push_frame(24'd7, 6);
    chg_k = 20;
    do_reset("s5");
    run(2 * FR);
    exp_win = '{24'd1, 24'd2, 24'd3, 24'd4, 24'd5, 24'd6};
    check_frame(0, "s5_f0", 6);
    exp_win = '{BG, BG, BG, BG, BG, BG};
    check_frame(1, "s5_f1", 0);
    check_err("s5", 2 * FR, 0, -1);
    check("s5_queue_held", 32'(q.size()), 32'd6);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
